hba_master: RTL and testbench

HBA_MASTER -- requirements
Module: hba_master

---
 rtl/hba_pkg.sv | 13 +
 rtl/hba_master.sv | 116 +++++++++++
 tb/tb_hba_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hba_pkg.sv
// Shared types and default bus geometry for the HBA bus master.
package hba_pkg;

   localparam int HBA_DBUS_WIDTH = 8;
   localparam int HBA_ADDR_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } hba_state_e;

endpackage

// File: rtl/hba_master.sv
// HBA bus master: turns one host request into one OR-bus transfer with ack timeout.
//
// state | meaning
// IDLE  | ready for a host request, bus driven to zero
// XFER  | hba_select high, waiting for slave ack or timeout
// RESP  | response held for host, bus driven to zero
module hba_master
   import hba_pkg::*;
#(
   parameter int DBUS_WIDTH     = HBA_DBUS_WIDTH,
   parameter int ADDR_WIDTH     = HBA_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rnw,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DBUS_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DBUS_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  hba_select,
   output logic                  hba_rnw,
   output logic [ADDR_WIDTH-1:0] hba_abus,
   output logic [DBUS_WIDTH-1:0] hba_dbus,
   input  logic [DBUS_WIDTH-1:0] hba_dbus_slave,
   input  logic                  hba_xferack
);

   localparam int CNT_W = 16;

   hba_state_e            state_q, state_d;
   logic                  rnw_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DBUS_WIDTH-1:0] wdata_q;
   logic [DBUS_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  cnt_tc;

   assign cnt_tc = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge hba_clk or negedge hba_reset) begin
      if (!hba_reset) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = XFER;
         XFER:    if (hba_xferack || cnt_tc) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs decode registered state/latches only, so they are glitch-free
   // and drop to zero the moment reset forces IDLE.
   always_comb begin
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      hba_select = 1'b0;
      hba_rnw    = 1'b0;
      hba_abus   = '0;
      hba_dbus   = '0;
      case (state_q)
         IDLE: req_ready = 1'b1;
         XFER: begin
            hba_select = 1'b1;
            hba_rnw    = rnw_q;
            hba_abus   = addr_q;
            hba_dbus   = rnw_q ? '0 : wdata_q;
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge hba_clk or negedge hba_reset) begin
      if (!hba_reset) begin
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         cnt_q <= (state_q == XFER) ? cnt_q + CNT_W'(1) : '0;
         if (state_q == IDLE && req_valid) begin
            rnw_q   <= req_rnw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
         // Ack takes priority over a timeout landing in the same cycle.
         if (state_q == XFER) begin
            if (hba_xferack) begin
               rdata_q <= rnw_q ? hba_dbus_slave : '0;
               err_q   <= 1'b0;
            end else if (cnt_tc) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
         end
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_hba_master.sv
// Directed bench for hba_master with an expected-response queue and handshake monitor.
module tb_hba_master;

   logic        hba_clk = 1'b0;
   logic        hba_reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rnw = 1'b0;
   logic [11:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        hba_select;
   logic        hba_rnw;
   logic [11:0] hba_abus;
   logic [7:0]  hba_dbus;
   logic [7:0]  hba_dbus_slave = '0;
   logic        hba_xferack = 1'b0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
   } exp_t;
   exp_t exp_q[$];

   hba_master #(.DBUS_WIDTH(8), .ADDR_WIDTH(12), .TIMEOUT_CYCLES(8)) dut (
      .hba_clk(hba_clk), .hba_reset(hba_reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .hba_select(hba_select), .hba_rnw(hba_rnw), .hba_abus(hba_abus), .hba_dbus(hba_dbus),
      .hba_dbus_slave(hba_dbus_slave), .hba_xferack(hba_xferack)
   );

   always #5 hba_clk = ~hba_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge hba_clk);
      #2;
   endtask

   // Monitor: consume one expected response per completed rsp handshake.
   initial begin
      forever begin
         @(negedge hba_clk);
         if (hba_reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("mon_unexpected_rsp", 32'(rsp_valid), 32'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("mon_rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
               chk("mon_rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end
      end
   end

   task automatic do_xfer(input logic rnw, input logic [11:0] addr, input logic [7:0] wdata,
                          input int ack_dly, input logic [7:0] sdata,
                          input logic [7:0] exp_rdata, input logic exp_err,
                          input int exp_sel, input int hold, input bit stray);
      int sel_cnt;
      exp_t e;
      chk("pre_req_ready", 32'(req_ready), 32'(1));
      req_valid = 1'b1;
      req_rnw   = rnw;
      req_addr  = addr;
      req_wdata = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      exp_q.push_back(e);
      chk("pre_select_low", 32'(hba_select), 32'(0));
      step();
      req_valid = 1'b0;
      req_addr  = 12'hFFF;
      req_wdata = 8'hFF;
      chk("select_n1", 32'(hba_select), 32'(1));
      chk("xfer_rnw", 32'(hba_rnw), 32'(rnw));
      chk("xfer_abus", 32'(hba_abus), 32'(addr));
      chk("xfer_dbus", 32'(hba_dbus), rnw ? 32'(0) : 32'(wdata));
      chk("xfer_req_ready", 32'(req_ready), 32'(0));
      sel_cnt = 1;
      while (1) begin
         if (sel_cnt - 1 == ack_dly) begin
            hba_xferack    = 1'b1;
            hba_dbus_slave = sdata;
         end
         step();
         hba_xferack    = 1'b0;
         hba_dbus_slave = '0;
         if (!hba_select) break;
         sel_cnt++;
         if (sel_cnt > 100) begin
            chk("xfer_bound", 32'(sel_cnt), 32'(exp_sel));
            return;
         end
      end
      chk("select_cycles", 32'(sel_cnt), 32'(exp_sel));
      chk("rsp_valid_up", 32'(rsp_valid), 32'(1));
      chk("resp_bus_zero", {20'(hba_abus), hba_dbus, 3'b0, hba_rnw}, 32'(0));
      for (int i = 0; i < hold; i++) begin
         if (stray) begin
            hba_xferack    = 1'b1;
            hba_dbus_slave = 8'hEE;
            req_valid      = 1'b1;
            req_addr       = 12'h7A0 + 12'(i);
         end
         step();
         chk("hold_rsp_valid", 32'(rsp_valid), 32'(1));
         chk("hold_rdata", 32'(rsp_rdata), 32'(exp_rdata));
         chk("hold_err", 32'(rsp_err), 32'(exp_err));
         chk("hold_req_ready", 32'(req_ready), 32'(0));
         chk("hold_no_select", 32'(hba_select), 32'(0));
      end
      hba_xferack    = 1'b0;
      hba_dbus_slave = '0;
      req_valid      = 1'b0;
      rsp_ready      = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("post_req_ready", 32'(req_ready), 32'(1));
      chk("post_select", 32'(hba_select), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      #3;
      chk("rst_select", 32'(hba_select), 32'(0));
      chk("rst_bus", {20'(hba_abus), hba_dbus, 3'b0, hba_rnw}, 32'(0));
      chk("rst_rsp", {23'(rsp_rdata), rsp_err, 7'b0, rsp_valid}, 32'(0));
      repeat (2) @(posedge hba_clk);
      #2;
      hba_reset = 1'b1;
      step();
      chk("rel_req_ready", 32'(req_ready), 32'(1));

      // Stray ack while idle must not move the FSM.
      hba_xferack = 1'b1;
      step();
      hba_xferack = 1'b0;
      chk("idle_ack_select", 32'(hba_select), 32'(0));
      chk("idle_ack_ready", 32'(req_ready), 32'(1));
      chk("idle_ack_rsp", 32'(rsp_valid), 32'(0));

      //       rnw   addr     wdata  dly sdata  exp_rd exp_err sel hold stray
      do_xfer(1'b0, 12'h103, 8'h5A, 1, 8'h77, 8'h00, 1'b0, 2, 0, 0);
      do_xfer(1'b1, 12'h201, 8'h99, 0, 8'hC3, 8'hC3, 1'b0, 1, 0, 0);
      do_xfer(1'b1, 12'hF00, 8'h00, -1, 8'h00, 8'h00, 1'b1, 8, 0, 0);
      do_xfer(1'b1, 12'h0A5, 8'h00, 7, 8'h11, 8'h11, 1'b0, 8, 0, 0);
      do_xfer(1'b0, 12'h3C7, 8'h96, 2, 8'h00, 8'h00, 1'b0, 3, 5, 1);
      do_xfer(1'b1, 12'h456, 8'h00, 3, 8'hB4, 8'hB4, 1'b0, 4, 5, 1);
      do_xfer(1'b1, 12'h777, 8'h00, 6, 8'h3E, 8'h3E, 1'b0, 7, 1, 0);

      // Reset in the middle of a transfer: no response may ever appear.
      req_valid = 1'b1;
      req_rnw   = 1'b1;
      req_addr  = 12'h444;
      step();
      req_valid = 1'b0;
      step();
      chk("mid_select_high", 32'(hba_select), 32'(1));
      hba_reset = 1'b0;
      #1;
      chk("mid_rst_select", 32'(hba_select), 32'(0));
      chk("mid_rst_abus", 32'(hba_abus), 32'(0));
      step();
      chk("mid_rst_rsp", 32'(rsp_valid), 32'(0));
      hba_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("after_rst_rsp", 32'(rsp_valid), 32'(0));
         chk("after_rst_ready", 32'(req_ready), 32'(1));
         chk("after_rst_select", 32'(hba_select), 32'(0));
      end

      do_xfer(1'b1, 12'h123, 8'h00, 0, 8'h5C, 8'h5C, 1'b0, 1, 0, 0);

      step();
      chk("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
